// File: rtl/cpu_defs_pkg.sv
// rtl/cpu_defs_pkg.sv - shared CPU definitions: MDU op encodings and latency defaults
package cpu_defs;

  localparam logic [2:0] MDU_MULT  = 3'd0;
  localparam logic [2:0] MDU_MULTU = 3'd1;
  localparam logic [2:0] MDU_DIV   = 3'd2;
  localparam logic [2:0] MDU_DIVU  = 3'd3;
  localparam logic [2:0] MDU_MTHI  = 3'd4;
  localparam logic [2:0] MDU_MTLO  = 3'd5;
  localparam logic [2:0] MDU_MFHI  = 3'd6;
  localparam logic [2:0] MDU_MFLO  = 3'd7;

  localparam int MUL_CYC_DEF = 5;
  localparam int DIV_CYC_DEF = 10;

  function automatic logic is_md_op(input logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic is_mul_op(input logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU);
  endfunction

endpackage

// File: rtl/mdu_core.sv
// rtl/mdu_core.sv - combinational 64-bit multiply and 32-bit div/rem for the MDU
module mdu_core
  import cpu_defs::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        res_valid
);

  logic        is_signed;
  logic        a_neg;
  logic        b_neg;
  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic [63:0] prod;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] b_div;
  logic [31:0] uq;
  logic [31:0] ur;
  logic [31:0] sq;
  logic [31:0] sr;

  always_comb begin
    is_signed = (op == MDU_MULT) || (op == MDU_DIV);
    a_neg     = is_signed & a[31];
    b_neg     = is_signed & b[31];
    // low 64 bits of the extended product are right for both signed and unsigned
    a_ext     = {{32{a_neg}}, a};
    b_ext     = {{32{b_neg}}, b};
    prod      = a_ext * b_ext;
    // magnitude divide; 0x80000000 / -1 wraps back to 0x80000000 with remainder 0
    a_mag     = a_neg ? (~a + 32'd1) : a;
    b_mag     = b_neg ? (~b + 32'd1) : b;
    b_div     = (b_mag == 32'd0) ? 32'd1 : b_mag;
    uq        = a_mag / b_div;
    ur        = a_mag % b_div;
    sq        = (a_neg ^ b_neg) ? (~uq + 32'd1) : uq;
    sr        = a_neg ? (~ur + 32'd1) : ur;

    res_hi    = 32'd0;
    res_lo    = 32'd0;
    res_valid = 1'b0;
    case (op)
      MDU_MULT, MDU_MULTU: begin
        {res_hi, res_lo} = prod;
        res_valid        = 1'b1;
      end
      MDU_DIV, MDU_DIVU: begin
        res_hi    = sr;
        res_lo    = sq;
        res_valid = (b != 32'd0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ex_mdu.sv
// rtl/ex_mdu.sv - EX-stage multiply/divide unit owning HI/LO with multi-cycle busy
module ex_mdu
  import cpu_defs::*;
#(
  parameter int MUL_CYC = MUL_CYC_DEF,
  parameter int DIV_CYC = DIV_CYC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] mf_out
);

  localparam int CYC_MAX = (MUL_CYC > DIV_CYC) ? MUL_CYC : DIV_CYC;
  localparam int CNT_W   = $clog2(CYC_MAX + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [31:0]      pend_hi_q, pend_hi_d;
  logic [31:0]      pend_lo_q, pend_lo_d;
  logic             pend_valid_q, pend_valid_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;

  logic [31:0]      res_hi;
  logic [31:0]      res_lo;
  logic             res_valid;

  mdu_core u_core (
    .op        (op),
    .a         (A),
    .b         (B),
    .res_hi    (res_hi),
    .res_lo    (res_lo),
    .res_valid (res_valid)
  );

  always_comb begin
    cnt_d        = cnt_q;
    busy_d       = busy_q;
    pend_hi_d    = pend_hi_q;
    pend_lo_d    = pend_lo_q;
    pend_valid_d = pend_valid_q;
    hi_d         = hi_q;
    lo_d         = lo_q;

    if (busy_q) begin
      // requests arriving while busy are dropped; hazard control never sends them
      if (cnt_q == CNT_W'(1)) begin
        busy_d = 1'b0;
        cnt_d  = '0;
        if (pend_valid_q) begin
          hi_d = pend_hi_q;
          lo_d = pend_lo_q;
        end
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end else if (start) begin
      if (is_md_op(op)) begin
        pend_hi_d    = res_hi;
        pend_lo_d    = res_lo;
        pend_valid_d = res_valid;
        cnt_d        = is_mul_op(op) ? CNT_W'(MUL_CYC) : CNT_W'(DIV_CYC);
        busy_d       = 1'b1;
      end else if (op == MDU_MTHI) begin
        hi_d = A;
      end else if (op == MDU_MTLO) begin
        lo_d = A;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      pend_hi_q    <= '0;
      pend_lo_q    <= '0;
      pend_valid_q <= 1'b0;
      hi_q         <= '0;
      lo_q         <= '0;
    end else begin
      cnt_q        <= cnt_d;
      busy_q       <= busy_d;
      pend_hi_q    <= pend_hi_d;
      pend_lo_q    <= pend_lo_d;
      pend_valid_q <= pend_valid_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
    end
  end

  always_comb begin
    mf_out = 32'd0;
    if (op == MDU_MFHI) mf_out = hi_q;
    else if (op == MDU_MFLO) mf_out = lo_q;
  end

  assign busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_ex_mdu.sv
// tb/tb_ex_mdu.sv - scoreboard bench for ex_mdu
module tb_ex_mdu;
  import cpu_defs::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        start2 = 1'b0;
  logic [2:0]  op = MDU_MFHI;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        busy, busy2;
  logic [31:0] HI, LO, mf_out, HI2, LO2, mf_out2;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;
  logic [63:0] sb_q[$];

  always #5 clk = ~clk;

  ex_mdu dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
    .busy(busy), .HI(HI), .LO(LO), .mf_out(mf_out)
  );

  ex_mdu #(.MUL_CYC(1), .DIV_CYC(3)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .op(op), .A(A), .B(B),
    .busy(busy2), .HI(HI2), .LO(LO2), .mf_out(mf_out2)
  );

  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, b,
                                        input logic [31:0] hi, lo);
    longint          sp;
    longint unsigned up;
    int              sa, sbv;
    case (o)
      MDU_MULT: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        return sp;
      end
      MDU_MULTU: begin
        up = {32'd0, a} * {32'd0, b};
        return up;
      end
      MDU_DIV: begin
        if (b == 32'd0) return {hi, lo};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
        sa  = a;
        sbv = b;
        return {32'(sa % sbv), 32'(sa / sbv)};
      end
      MDU_DIVU: begin
        if (b == 32'd0) return {hi, lo};
        return {a % b, a / b};
      end
      default: return {hi, lo};
    endcase
  endfunction

  task automatic issue(input logic [2:0] o, input logic [31:0] a, b);
    @(negedge clk);
    start = 1'b1; op = o; A = a; B = b;
    @(negedge clk);
    start = 1'b0; A = $urandom; B = $urandom;
  endtask

  task automatic run_md(input string name, input logic [2:0] o, input logic [31:0] a, b,
                        input int ncyc, input bit poke, input bit peek);
    int cnt;
    logic [63:0] e;
    sb_q.push_back(model(o, a, b, exp_hi, exp_lo));
    issue(o, a, b);
    cnt = 0;
    while (busy === 1'b1 && cnt < 64) begin
      cnt++;
      if (poke && cnt == 2) begin start = 1'b1; op = MDU_MTLO; A = 32'd5; end
      else start = 1'b0;
      if (peek && cnt == 3) begin
        op = MDU_MFLO;
        #1;
        tests++;
        if (mf_out !== exp_lo) begin
          fails++; $display("FAIL %s mflo_busy: mf_out=%h expected %h", name, mf_out, exp_lo);
        end
      end
      @(negedge clk);
    end
    start = 1'b0;
    tests++;
    if (cnt != ncyc) begin
      fails++; $display("FAIL %s busy_cycles: got %0d expected %0d", name, cnt, ncyc);
    end
    e = sb_q.pop_front();
    tests++;
    if ({HI, LO} !== e) begin
      fails++; $display("FAIL %s result: HI=%h LO=%h expected HI=%h LO=%h", name, HI, LO, e[63:32], e[31:0]);
    end
    exp_hi = e[63:32];
    exp_lo = e[31:0];
  endtask

  task automatic do_mt(input logic [2:0] o, input logic [31:0] a);
    issue(o, a, 32'd0);
    if (o == MDU_MTHI) exp_hi = a; else exp_lo = a;
    tests++;
    if (busy !== 1'b0 || HI !== exp_hi || LO !== exp_lo) begin
      fails++; $display("FAIL mt: busy=%b HI=%h LO=%h expected busy=0 HI=%h LO=%h", busy, HI, LO, exp_hi, exp_lo);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0 || mf_out !== 32'd0) begin
      fails++; $display("FAIL reset: busy=%b HI=%h LO=%h mf=%h expected 0", busy, HI, LO, mf_out);
    end
    reset = 1'b1;
  endtask

  task automatic test_mult();
    run_md("mult", MDU_MULT, 32'hFFFFFFFE, 32'd3, 5, 0, 0);
    tests++;
    if (HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFFA) begin
      fails++; $display("FAIL mult_const: HI=%h LO=%h expected ffffffff fffffffa", HI, LO);
    end
    run_md("multu", MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 0, 0);
    tests++;
    if (HI !== 32'hFFFFFFFE || LO !== 32'h00000001) begin
      fails++; $display("FAIL multu_const: HI=%h LO=%h expected fffffffe 00000001", HI, LO);
    end
  endtask

  task automatic test_div();
    run_md("div", MDU_DIV, 32'hFFFFFFF9, 32'd2, 10, 0, 0);
    tests++;
    if (HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFFD) begin
      fails++; $display("FAIL div_const: HI=%h LO=%h expected ffffffff fffffffd", HI, LO);
    end
    run_md("divu", MDU_DIVU, 32'hFFFFFFF9, 32'd2, 10, 0, 0);
    tests++;
    if (HI !== 32'd1 || LO !== 32'h7FFFFFFC) begin
      fails++; $display("FAIL divu_const: HI=%h LO=%h expected 00000001 7ffffffc", HI, LO);
    end
    run_md("div_ovf", MDU_DIV, 32'h80000000, 32'hFFFFFFFF, 10, 0, 0);
    tests++;
    if (HI !== 32'd0 || LO !== 32'h80000000) begin
      fails++; $display("FAIL div_ovf_const: HI=%h LO=%h expected 00000000 80000000", HI, LO);
    end
  endtask

  task automatic test_div_zero();
    do_mt(MDU_MTHI, 32'h1234);
    run_md("div0", MDU_DIV, 32'd77, 32'd0, 10, 0, 0);
    tests++;
    if (HI !== 32'h1234) begin
      fails++; $display("FAIL div0_hi: HI=%h expected 00001234", HI);
    end
    run_md("divu0", MDU_DIVU, 32'd77, 32'd0, 10, 0, 0);
    @(negedge clk);
    op = MDU_MFHI;
    #1;
    tests++;
    if (mf_out !== 32'h1234) begin
      fails++; $display("FAIL mfhi: mf_out=%h expected 00001234", mf_out);
    end
  endtask

  task automatic test_busy_ignore();
    do_mt(MDU_MTLO, 32'hCAFE0000);
    run_md("ignore_mtlo", MDU_MULT, 32'd7, 32'd9, 5, 1, 0);
    run_md("mflo_busy", MDU_MULTU, 32'h10, 32'h20, 5, 0, 1);
  endtask

  task automatic test_back_to_back();
    logic [2:0]  o;
    logic [31:0] a, b;
    for (int i = 0; i < 8; i++) begin
      o = 3'($urandom_range(0, 3));
      a = $urandom;
      b = (i == 5) ? 32'd0 : ((i % 2) ? $urandom : 32'($urandom_range(1, 300)));
      run_md("b2b", o, a, b, is_mul_op(o) ? 5 : 10, 0, 0);
    end
  endtask

  task automatic test_reset_mid();
    issue(MDU_DIV, 32'd50, 32'd5);
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    tests++;
    if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
      fails++; $display("FAIL reset_mid: busy=%b HI=%h LO=%h expected 0 0 0", busy, HI, LO);
    end
    @(negedge clk);
    reset = 1'b1;
    exp_hi = '0;
    exp_lo = '0;
    repeat (12) @(negedge clk);
    tests++;
    if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
      fails++; $display("FAIL reset_drop: busy=%b HI=%h LO=%h expected 0 0 0", busy, HI, LO);
    end
  endtask

  task automatic test_short_params();
    int cnt;
    logic [2:0]  ops[2]  = '{MDU_MULT, MDU_DIV};
    logic [31:0] as[2]   = '{32'd3, 32'd100};
    logic [31:0] bs[2]   = '{32'd4, 32'd7};
    logic [63:0] ex[2]   = '{{32'd0, 32'd12}, {32'd2, 32'd14}};
    int          cyc[2]  = '{1, 3};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      start2 = 1'b1; op = ops[i]; A = as[i]; B = bs[i];
      @(negedge clk);
      start2 = 1'b0; A = $urandom; B = $urandom;
      cnt = 0;
      while (busy2 === 1'b1 && cnt < 16) begin
        cnt++;
        @(negedge clk);
      end
      tests++;
      if (cnt != cyc[i]) begin
        fails++; $display("FAIL short_busy%0d: got %0d expected %0d", i, cnt, cyc[i]);
      end
      tests++;
      if ({HI2, LO2} !== ex[i]) begin
        fails++; $display("FAIL short_res%0d: HI=%h LO=%h expected %h", i, HI2, LO2, ex[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    test_short_params();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
